// File: rtl/ps2_text_buffer.sv
// PS/2 scancode to character buffer: decodes make/break/extended prefixes, tracks Shift,
// edits a COLS x ROWS character RAM at a cursor and serves a registered renderer read port.
module ps2_text_buffer #(
    parameter int          COLS       = 12,
    parameter int          ROWS       = 9,
    parameter logic [7:0]  FILL_CHAR  = 8'h20,
    parameter bit          WRAP       = 1'b1,
    parameter logic [7:0]  CODE_BS    = 8'h66,
    parameter logic [7:0]  CODE_ENTER = 8'h5A,
    localparam int         N          = COLS * ROWS,
    localparam int         IDX_W      = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_err,
    input  logic             clear,
    output logic [7:0]       lut_addr,
    input  logic [7:0]       lut_ascii,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic [IDX_W-1:0] cursor,
    output logic             shift_on,
    output logic             full,
    output logic             busy,
    output logic             wr_valid,
    output logic [IDX_W-1:0] wr_index,
    output logic [7:0]       wr_char
);

    typedef enum logic [1:0] {CLEAR, IDLE, LOOKUP, WRITE} state_t;

    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_reg;
    logic [IDX_W-1:0] sweep_reg;
    logic [IDX_W-1:0] cursor_reg;
    logic             brk_reg, ext_reg, shift_reg, full_reg;
    logic             wr_valid_reg;
    logic [IDX_W-1:0] wr_index_reg;
    logic [7:0]       wr_char_reg, lut_addr_reg, rd_data_reg;

    logic [7:0]       mem [N];

    logic             is_shift, plain_key, bs_hit, put_ok;
    logic [7:0]       put_char;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [7:0]       mem_wdata;
    int               enter_pos;
    logic [IDX_W-1:0] enter_cursor, inc_cursor;
    logic             enter_full, inc_full;

    assign is_shift  = (rx_data == 8'h12) || (rx_data == 8'h59);
    // A byte that reaches the key actions: valid, not a prefix, no pending prefix, not Shift.
    assign plain_key = (state_reg == IDLE) && !clear && rx_valid && !rx_err &&
                       (rx_data != 8'hE0) && (rx_data != 8'hF0) && !brk_reg && !ext_reg && !is_shift;
    assign bs_hit    = plain_key && (rx_data == CODE_BS) && (cursor_reg != '0);
    assign put_ok    = (state_reg == WRITE) && (lut_ascii != 8'h00) && !full_reg;

    always_comb begin
        put_char = lut_ascii;
        if (shift_reg && lut_ascii >= 8'h61 && lut_ascii <= 8'h7A)
            put_char = lut_ascii - 8'h20;
    end

    always_comb begin
        enter_pos    = (int'(cursor_reg) / COLS + 1) * COLS;
        enter_full   = 1'b0;
        enter_cursor = IDX_W'(enter_pos);
        if (enter_pos >= N) begin
            enter_cursor = WRAP ? '0 : N_IDX;
            enter_full   = !WRAP;
        end
        inc_cursor = cursor_reg + 1'b1;
        inc_full   = 1'b0;
        if (cursor_reg == LAST_IDX) begin
            inc_cursor = WRAP ? '0 : N_IDX;
            inc_full   = !WRAP;
        end
    end

    // Single RAM write port shared by the clear sweep, backspace and character writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = FILL_CHAR;
        if (state_reg == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_reg;
        end else if (bs_hit) begin
            mem_we    = 1'b1;
            mem_waddr = cursor_reg - 1'b1;
        end else if (put_ok) begin
            mem_we    = 1'b1;
            mem_waddr = cursor_reg;
            mem_wdata = put_char;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Read-first: a same-cycle write to rd_addr is seen on the following read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data_reg <= FILL_CHAR;
        else if (rd_addr < N_IDX)
            rd_data_reg <= mem[rd_addr];
        else
            rd_data_reg <= FILL_CHAR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= CLEAR;
            sweep_reg    <= '0;
            cursor_reg   <= '0;
            brk_reg      <= 1'b0;
            ext_reg      <= 1'b0;
            shift_reg    <= 1'b0;
            full_reg     <= 1'b0;
            wr_valid_reg <= 1'b0;
            wr_index_reg <= '0;
            wr_char_reg  <= 8'h00;
            lut_addr_reg <= 8'h00;
        end else begin
            wr_valid_reg <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    if (sweep_reg == LAST_IDX) begin
                        state_reg  <= IDLE;
                        sweep_reg  <= '0;
                        cursor_reg <= '0;
                        full_reg   <= 1'b0;
                        brk_reg    <= 1'b0;
                        ext_reg    <= 1'b0;
                    end else begin
                        sweep_reg <= sweep_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state_reg <= CLEAR;
                        sweep_reg <= '0;
                    end else if (rx_valid) begin
                        if (rx_err) begin
                            brk_reg <= 1'b0;
                            ext_reg <= 1'b0;
                        end else if (rx_data == 8'hE0) begin
                            ext_reg <= 1'b1;
                        end else if (rx_data == 8'hF0) begin
                            brk_reg <= 1'b1;
                        end else if (brk_reg) begin
                            if (is_shift)
                                shift_reg <= 1'b0;
                            brk_reg <= 1'b0;
                            ext_reg <= 1'b0;
                        end else if (ext_reg) begin
                            ext_reg <= 1'b0;
                        end else if (is_shift) begin
                            shift_reg <= 1'b1;
                        end else if (rx_data == CODE_BS) begin
                            if (bs_hit) begin
                                cursor_reg   <= cursor_reg - 1'b1;
                                full_reg     <= 1'b0;
                                wr_valid_reg <= 1'b1;
                                wr_index_reg <= cursor_reg - 1'b1;
                                wr_char_reg  <= FILL_CHAR;
                            end
                        end else if (rx_data == CODE_ENTER) begin
                            cursor_reg <= enter_cursor;
                            full_reg   <= enter_full;
                        end else begin
                            lut_addr_reg <= rx_data;
                            state_reg    <= LOOKUP;
                        end
                    end
                end
                LOOKUP: state_reg <= WRITE;
                WRITE: begin
                    if (put_ok) begin
                        wr_valid_reg <= 1'b1;
                        wr_index_reg <= cursor_reg;
                        wr_char_reg  <= put_char;
                        cursor_reg   <= inc_cursor;
                        full_reg     <= inc_full;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    assign lut_addr = lut_addr_reg;
    assign rd_data  = rd_data_reg;
    assign cursor   = cursor_reg;
    assign shift_on = shift_reg;
    assign full     = full_reg;
    assign busy     = (state_reg != IDLE);
    assign wr_valid = wr_valid_reg;
    assign wr_index = wr_index_reg;
    assign wr_char  = wr_char_reg;

endmodule

// File: tb/tb_ps2_text_buffer.sv
// Directed bench for ps2_text_buffer: a wrapping instance and a saturating instance
// share all stimulus; each has its own scancode ROM model.
module tb_ps2_text_buffer;

    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_valid, rx_err, clear;
    logic [IDX_W-1:0] rd_addr;

    logic [7:0]       lut_addr, lut_ascii, rd_data, wr_char;
    logic [IDX_W-1:0] cursor, wr_index;
    logic             shift_on, full, busy, wr_valid;

    logic [7:0]       lut_addr0, lut_ascii0, rd_data0, wr_char0;
    logic [IDX_W-1:0] cursor0, wr_index0;
    logic             shift_on0, full0, busy0, wr_valid0;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int wr_cnt0 = 0;
    int snap, snap0, cyc;
    logic [7:0] rd_last;
    logic [7:0] last_char;
    logic [IDX_W-1:0] last_idx;

    always #5 clk = ~clk;

    ps2_text_buffer dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .clear(clear), .lut_addr(lut_addr), .lut_ascii(lut_ascii), .rd_addr(rd_addr),
        .rd_data(rd_data), .cursor(cursor), .shift_on(shift_on), .full(full), .busy(busy),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_char(wr_char)
    );

    ps2_text_buffer #(.WRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .clear(clear), .lut_addr(lut_addr0), .lut_ascii(lut_ascii0), .rd_addr(rd_addr),
        .rd_data(rd_data0), .cursor(cursor0), .shift_on(shift_on0), .full(full0), .busy(busy0),
        .wr_valid(wr_valid0), .wr_index(wr_index0), .wr_char(wr_char0)
    );

    function automatic logic [7:0] rom(input logic [7:0] code);
        case (code)
            8'h1C:   rom = 8'h61;
            8'h32:   rom = 8'h62;
            8'h21:   rom = 8'h63;
            8'h16:   rom = 8'h31;
            default: rom = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        lut_ascii  <= rom(lut_addr);
        lut_ascii0 <= rom(lut_addr0);
    end

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            last_idx  = wr_index;
            last_char = wr_char;
        end
        if (wr_valid0)
            wr_cnt0++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e);
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_err   = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        repeat (4) @(negedge clk);
        $display("tx byte=%02h err=%0b cursor=%0d cursor0=%0d", d, e, cursor, cursor0);
    endtask

    task automatic read_cell(input int a, output logic [7:0] d, output logic [7:0] d0);
        @(negedge clk);
        rd_addr = IDX_W'(a);
        @(negedge clk);
        d  = rd_data;
        d0 = rd_data0;
    endtask

    task automatic wait_idle(input string tag);
        cyc = 0;
        while ((busy || busy0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {31'd0, busy | busy0}, 32'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_idle("clear_done");
        $display("tx clear cursor=%0d", cursor);
    endtask

    task automatic count_clear(input string tag);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!busy) break;
        end
        check(tag, cyc, 108);
    endtask

    logic [7:0] d, d0;
    logic found;

    initial begin
        reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; clear = 1'b0; rd_addr = '0;

        // 1: reset values, clear sweep length, blank buffer
        repeat (3) @(negedge clk);
        check("rst_cursor", cursor, 0);
        check("rst_busy", busy, 1);
        check("rst_rd_data", rd_data, 8'h20);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_shift", shift_on, 0);
        check("rst_full0", full0, 0);
        check("rst_lut_addr", lut_addr, 0);
        reset = 1'b1;
        count_clear("clear_cycles");
        for (int i = 0; i < 108; i++) begin
            read_cell(i, d, d0);
            check($sformatf("blank_cell%0d", i), d, 8'h20);
        end
        read_cell(108, d, d0);
        check("rd_out_of_range", d, 8'h20);
        check("t1_cursor", cursor, 0);

        // 2: shifted letter with read-first observation, then release Shift
        send_byte(8'h12, 1'b0);
        check("shift_held", shift_on, 1);
        snap = wr_cnt;
        @(negedge clk);
        rd_addr  = '0;
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("wr_pulse_seen", found, 1);
        check("read_first_old", rd_data, 8'h20);
        check("wr_index_A", wr_index, 0);
        check("wr_char_A", wr_char, 8'h41);
        @(negedge clk);
        rd_last = rd_data;
        check("read_after_write", rd_last, 8'h41);
        check("wr_valid_one_pulse", wr_valid, 0);
        repeat (2) @(negedge clk);
        check("wr_count_A", wr_cnt - snap, 1);
        check("cursor_after_A", cursor, 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        check("shift_released", shift_on, 0);
        send_byte(8'h1C, 1'b0);
        read_cell(1, d, d0);
        check("cell1_lower", d, 8'h61);
        check("cursor_after_a", cursor, 2);

        // 3: break and extended codes write nothing; corrupt prefix is discarded
        snap = wr_cnt;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("prefix_no_write", wr_cnt - snap, 0);
        check("prefix_cursor", cursor, 2);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h1C, 1'b0);
        check("err_prefix_write", wr_cnt - snap, 1);
        read_cell(2, d, d0);
        check("cell2_after_err", d, 8'h61);
        check("cursor_after_err", cursor, 3);

        // 4: Enter moves to the next row; Backspace erases and stops at zero
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("cursor_5", cursor, 5);
        send_byte(8'h5A, 1'b0);
        check("enter_cursor", cursor, 12);
        do_clear();
        send_byte(8'h1C, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h21, 1'b0);
        check("cursor_3", cursor, 3);
        snap = wr_cnt;
        send_byte(8'h66, 1'b0);
        check("bs_cursor", cursor, 2);
        check("bs_wr_pulse", wr_cnt - snap, 1);
        check("bs_wr_index", last_idx, 2);
        check("bs_wr_char", last_char, 8'h20);
        read_cell(2, d, d0);
        check("bs_cell2", d, 8'h20);
        read_cell(1, d, d0);
        check("bs_cell1_kept", d, 8'h62);
        send_byte(8'h66, 1'b0);
        send_byte(8'h66, 1'b0);
        check("bs_to_zero", cursor, 0);
        snap = wr_cnt;
        send_byte(8'h66, 1'b0);
        check("bs_at_zero_cursor", cursor, 0);
        check("bs_at_zero_nowrite", wr_cnt - snap, 0);

        // 5: wrap versus saturate after filling all 108 cells
        do_clear();
        for (int i = 0; i < 108; i++)
            send_byte(8'h1C, 1'b0);
        check("wrap_cursor_108", cursor, 0);
        check("sat_cursor_108", cursor0, 108);
        check("sat_full", full0, 1);
        check("wrap_not_full", full, 0);
        snap0 = wr_cnt0;
        send_byte(8'h32, 1'b0);
        read_cell(0, d, d0);
        check("wrap_cell0", d, 8'h62);
        check("sat_cell0", d0, 8'h61);
        check("wrap_cursor_109", cursor, 1);
        check("sat_dropped", wr_cnt0 - snap0, 0);
        check("sat_cursor_109", cursor0, 108);
        send_byte(8'h66, 1'b0);
        read_cell(107, d, d0);
        check("sat_bs_cell107", d0, 8'h20);
        check("sat_bs_full", full0, 0);
        check("sat_bs_cursor", cursor0, 107);

        // 6: clear beats a same-cycle byte; reset during lookup aborts the write
        snap = wr_cnt;
        @(negedge clk);
        clear    = 1'b1;
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        rx_valid = 1'b0;
        check("clear_wins_busy", busy, 1);
        wait_idle("clear_wins_done");
        check("clear_wins_nowrite", wr_cnt - snap, 0);
        check("clear_wins_cursor", cursor, 0);
        read_cell(0, d, d0);
        check("clear_wins_cell0", d, 8'h20);

        snap = wr_cnt;
        @(negedge clk);
        rx_data  = 8'h1C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("lookup_busy", busy, 1);
        check("lookup_addr", lut_addr, 8'h1C);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_lut_addr", lut_addr, 0);
        reset = 1'b1;
        count_clear("reclear_cycles");
        check("abort_nowrite", wr_cnt - snap, 0);
        check("abort_cursor", cursor, 0);
        read_cell(0, d, d0);
        check("abort_cell0", d, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
